ram_arb_ctrl: RTL and testbench
===============================

RAM_ARB_CTRL -- requirements
Module: ram_arb_ctrl

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 50000: clock cycles per read-address step; legal range 4..65535.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port clrn, input, 1 bit: reset, synchronous and active-low.
REQ-004 SHALL have ports req_a / req_b, input, 1 bit each: write request from client A / B, held high until the matching ack.
REQ-005 SHALL have ports addr_a / addr_b, input, 4 bits each: write address of client A / B.
REQ-006 SHALL have ports data_a / data_b, input, 8 bits each: write data of client A / B.
REQ-007 SHALL have ports ack_a / ack_b, output, 1 bit each: one-cycle pulse meaning the request was written this cycle.
REQ-008 SHALL have port scan_en, input, 1 bit: enables the display read scanner.
REQ-009 SHALL have port ram_wren, output, 1 bit: write enable to the 16x8 dual-port RAM.
REQ-010 SHALL have port ram_wraddr, output, 4 bits: RAM write address.
REQ-011 SHALL have port ram_data, output, 8 bits: RAM write data.
REQ-012 SHALL have port ram_rdaddr, output, 4 bits: RAM read address.
REQ-013 SHALL have port ram_q, input, 8 bits: RAM read data, valid 1 cycle after ram_rdaddr (registered read).
REQ-014 SHALL have ports disp_addr, output, 4 bits, and disp_data, output, 8 bits: last scanned address and its data, for the 7-segment decoders.
REQ-015 SHALL have port disp_valid, output, 1 bit: one-cycle pulse when disp_addr/disp_data update.

Function
REQ-016 All outputs SHALL be registered.
REQ-017 The write arbiter SHALL be an FSM with two states: IDLE and WRITE.
REQ-018 In IDLE with at least one req high at an edge: next state WRITE; ram_wren=1; ram_wraddr/ram_data = granted client's addr/data; that client's ack=1, all for exactly that one cycle.
REQ-019 WRITE SHALL always return to IDLE; no grant is taken in WRITE, so writes occur at most every second cycle.
REQ-020 Grant SHALL be round-robin: a sole requester wins; on simultaneous requests the client not granted last wins; after reset A has priority.
REQ-021 A client SHALL deassert req in the cycle after its ack; req still high in IDLE SHALL be treated as a new request.
REQ-022 Outside a write cycle: ram_wren=0, acks=0, ram_wraddr/ram_data hold their last value.
REQ-023 Scanner: with scan_en=1, a 16-bit divider SHALL count 0..SCAN_DIV-1 and wrap; at terminal count ram_rdaddr increments modulo 16 (15 -> 0) on the next edge.
REQ-024 With scan_en=0, the divider, ram_rdaddr and disp_* SHALL hold; raising scan_en resumes from the held count.
REQ-025 Two cycles after each ram_rdaddr change, disp_addr SHALL take the new address, disp_data SHALL take ram_q, and disp_valid SHALL pulse for 1 cycle.
REQ-026 A capture pipelined in flight when scan_en falls SHALL still complete.
REQ-027 Read and write SHALL be independent; a same-address collision needs no special handling, and the RAM's old-data result is accepted.

Reset
REQ-028 With clrn=0 at an edge, the following SHALL be 0: FSM (state IDLE), round-robin pointer (A priority), divider, ram_rdaddr, capture pipeline, and every output.
REQ-029 Reset SHALL override all other inputs, including mid-write and mid-capture.
REQ-030 A request interrupted by reset SHALL get no ack; the client re-requests.

Verification
REQ-031 Sole req_a, addr_a=3, data_a=0x02 -> next cycle ram_wren=1, ram_wraddr=3, ram_data=0x02, ack_a=1; ack_b=0.
REQ-032 req_a and req_b both held high from reset -> writes alternate A, B, A, B, one per two cycles; each ack is one cycle wide.
REQ-033 SCAN_DIV=4, scan_en=1 from reset -> ram_rdaddr steps every 4 cycles, 0..15 then wraps to 0; disp_valid pulses 2 cycles after each step with disp_data = RAM content at that address.
REQ-034 Write 0x01 to address 5, then scan to address 5 -> disp_addr=5, disp_data=0x01.
REQ-035 scan_en dropped for 10 cycles mid-count -> ram_rdaddr and disp_* unchanged; after scan_en returns, stepping resumes with no skipped address.
REQ-036 clrn=0 in the WRITE cycle and during a pending capture -> the next cycle has all outputs 0, no ack, and no disp_valid.

Source files
------------

// File: rtl/ram_arb_ctrl.sv
// Write arbiter and display read scanner sitting in front of a 16x8 dual-port RAM.
// Two clients share the write port round-robin; the read port is swept slowly for a display.
module ram_arb_ctrl #(
  parameter int SCAN_DIV = 50000
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       req_a,
  input  logic       req_b,
  input  logic [3:0] addr_a,
  input  logic [3:0] addr_b,
  input  logic [7:0] data_a,
  input  logic [7:0] data_b,
  output logic       ack_a,
  output logic       ack_b,
  input  logic       scan_en,
  output logic       ram_wren,
  output logic [3:0] ram_wraddr,
  output logic [7:0] ram_data,
  output logic [3:0] ram_rdaddr,
  input  logic [7:0] ram_q,
  output logic [3:0] disp_addr,
  output logic [7:0] disp_data,
  output logic       disp_valid
);

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } state_t;

  localparam logic [15:0] DIV_LAST = 16'(SCAN_DIV - 1);
  localparam int          PIPE_LEN = 2;

  // ---------------- write arbiter ----------------
  state_t      state_reg, state_next;
  logic        prio_b_reg, prio_b_next;   // 1: B wins a tie
  logic        wren_reg, wren_next;
  logic        ack_a_reg, ack_a_next;
  logic        ack_b_reg, ack_b_next;
  logic [3:0]  wraddr_reg, wraddr_next;
  logic [7:0]  wdata_reg, wdata_next;

  always_comb begin
    state_next  = state_reg;
    prio_b_next = prio_b_reg;
    wren_next   = 1'b0;
    ack_a_next  = 1'b0;
    ack_b_next  = 1'b0;
    wraddr_next = wraddr_reg;
    wdata_next  = wdata_reg;
    case (state_reg)
      IDLE: begin
        if (req_a || req_b) begin
          state_next = WRITE;
          wren_next  = 1'b1;
          if (req_a && (!req_b || !prio_b_reg)) begin
            ack_a_next  = 1'b1;
            wraddr_next = addr_a;
            wdata_next  = data_a;
            prio_b_next = 1'b1;
          end else begin
            ack_b_next  = 1'b1;
            wraddr_next = addr_b;
            wdata_next  = data_b;
            prio_b_next = 1'b0;
          end
        end
      end
      WRITE:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clrn) begin
      state_reg  <= IDLE;
      prio_b_reg <= 1'b0;
      wren_reg   <= 1'b0;
      ack_a_reg  <= 1'b0;
      ack_b_reg  <= 1'b0;
      wraddr_reg <= 4'd0;
      wdata_reg  <= 8'd0;
    end else begin
      state_reg  <= state_next;
      prio_b_reg <= prio_b_next;
      wren_reg   <= wren_next;
      ack_a_reg  <= ack_a_next;
      ack_b_reg  <= ack_b_next;
      wraddr_reg <= wraddr_next;
      wdata_reg  <= wdata_next;
    end
  end

  // ---------------- read scanner ----------------
  logic [15:0] div_reg, div_next;
  logic [3:0]  rdaddr_reg, rdaddr_next;
  logic        step;

  assign step        = scan_en && (div_reg == DIV_LAST);
  assign div_next    = !scan_en ? div_reg : (step ? 16'd0 : div_reg + 16'd1);
  assign rdaddr_next = step ? rdaddr_reg + 4'd1 : rdaddr_reg;

  always_ff @(posedge clk) begin
    if (!clrn) begin
      div_reg    <= 16'd0;
      rdaddr_reg <= 4'd0;
    end else begin
      div_reg    <= div_next;
      rdaddr_reg <= rdaddr_next;
    end
  end

  // Capture pipeline: stage 0 is loaded with the step, the RAM answers one
  // cycle later, and the display registers grab ram_q one cycle after that.
  // It runs independently of scan_en so an in-flight capture always lands.
  logic       pipe_valid_reg [PIPE_LEN];
  logic [3:0] pipe_addr_reg  [PIPE_LEN];

  always_ff @(posedge clk) begin
    if (!clrn) begin
      pipe_valid_reg[0] <= 1'b0;
      pipe_addr_reg[0]  <= 4'd0;
    end else begin
      pipe_valid_reg[0] <= step;
      pipe_addr_reg[0]  <= rdaddr_next;
    end
  end

  generate
    for (genvar gi = 1; gi < PIPE_LEN; gi++) begin : g_pipe
      always_ff @(posedge clk) begin
        if (!clrn) begin
          pipe_valid_reg[gi] <= 1'b0;
          pipe_addr_reg[gi]  <= 4'd0;
        end else begin
          pipe_valid_reg[gi] <= pipe_valid_reg[gi-1];
          pipe_addr_reg[gi]  <= pipe_addr_reg[gi-1];
        end
      end
    end
  endgenerate

  logic       disp_valid_reg;
  logic [3:0] disp_addr_reg;
  logic [7:0] disp_data_reg;

  always_ff @(posedge clk) begin
    if (!clrn) begin
      disp_valid_reg <= 1'b0;
      disp_addr_reg  <= 4'd0;
      disp_data_reg  <= 8'd0;
    end else begin
      disp_valid_reg <= pipe_valid_reg[PIPE_LEN-1];
      if (pipe_valid_reg[PIPE_LEN-1]) begin
        disp_addr_reg <= pipe_addr_reg[PIPE_LEN-1];
        disp_data_reg <= ram_q;
      end
    end
  end

  assign ack_a      = ack_a_reg;
  assign ack_b      = ack_b_reg;
  assign ram_wren   = wren_reg;
  assign ram_wraddr = wraddr_reg;
  assign ram_data   = wdata_reg;
  assign ram_rdaddr = rdaddr_reg;
  assign disp_addr  = disp_addr_reg;
  assign disp_data  = disp_data_reg;
  assign disp_valid = disp_valid_reg;

endmodule

// File: tb/tb_ram_arb_ctrl.sv
// Scoreboard bench for ram_arb_ctrl: drivers push expected writes/captures,
// a negedge monitor pops them whenever the DUT shows ram_wren or disp_valid.
module tb_ram_arb_ctrl;

  localparam int SCAN_DIV = 4;

  logic       clk = 1'b0;
  logic       clrn = 1'b0;
  logic       req_a = 1'b0, req_b = 1'b0;
  logic [3:0] addr_a = 4'd0, addr_b = 4'd0;
  logic [7:0] data_a = 8'd0, data_b = 8'd0;
  logic       scan_en = 1'b0;
  logic       ack_a, ack_b, ram_wren, disp_valid;
  logic [3:0] ram_wraddr, ram_rdaddr, disp_addr;
  logic [7:0] ram_data, disp_data;
  logic [7:0] ram_q = 8'd0;

  ram_arb_ctrl #(.SCAN_DIV(SCAN_DIV)) dut (
    .clk(clk), .clrn(clrn),
    .req_a(req_a), .req_b(req_b),
    .addr_a(addr_a), .addr_b(addr_b),
    .data_a(data_a), .data_b(data_b),
    .ack_a(ack_a), .ack_b(ack_b),
    .scan_en(scan_en),
    .ram_wren(ram_wren), .ram_wraddr(ram_wraddr), .ram_data(ram_data),
    .ram_rdaddr(ram_rdaddr), .ram_q(ram_q),
    .disp_addr(disp_addr), .disp_data(disp_data), .disp_valid(disp_valid)
  );

  always #5 clk = ~clk;

  // 16x8 RAM with registered read, old data on collision; preloaded with A0+i.
  logic [7:0] mem [16];
  logic       loaded = 1'b0;
  always @(posedge clk) begin
    if (!loaded) begin
      for (int i = 0; i < 16; i++) mem[i] <= 8'hA0 + 8'(i);
      loaded <= 1'b1;
    end else if (ram_wren) begin
      mem[ram_wraddr] <= ram_data;
    end
    ram_q <= mem[ram_rdaddr];
  end

  typedef struct { logic b; logic [3:0] addr; logic [7:0] data; } wr_t;
  typedef struct { logic [3:0] addr; logic [7:0] data; } dp_t;
  wr_t wq[$];
  dp_t dq[$];
  logic [7:0] exp_mem [16];

  int checks = 0;
  int errors = 0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  // ---------------- monitor ----------------
  wr_t  mw;
  dp_t  md;
  logic prev_wren = 1'b0;
  always @(negedge clk) begin
    if (ram_wren) begin
      chk("write_spacing", {31'd0, prev_wren}, 32'd0);
      if (wq.size() == 0) begin
        chk("unexpected_write", 32'd1, 32'd0);
      end else begin
        mw = wq.pop_front();
        $display("write: addr=%0h data=%02h ack_a=%0b ack_b=%0b", ram_wraddr, ram_data, ack_a, ack_b);
        chk("wraddr", {28'd0, ram_wraddr}, {28'd0, mw.addr});
        chk("wdata", {24'd0, ram_data}, {24'd0, mw.data});
        chk("ack_a", {31'd0, ack_a}, {31'd0, !mw.b});
        chk("ack_b", {31'd0, ack_b}, {31'd0, mw.b});
      end
    end else if (ack_a || ack_b) begin
      chk("ack_without_write", {30'd0, ack_a, ack_b}, 32'd0);
    end
    prev_wren <= ram_wren;
    if (disp_valid) begin
      if (dq.size() == 0) begin
        chk("unexpected_disp", 32'd1, 32'd0);
      end else begin
        md = dq.pop_front();
        $display("disp: addr=%0h data=%02h", disp_addr, disp_data);
        chk("disp_addr", {28'd0, disp_addr}, {28'd0, md.addr});
        chk("disp_data", {24'd0, disp_data}, {24'd0, md.data});
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(string tag);
    chk({tag, "_ack_a"}, {31'd0, ack_a}, 32'd0);
    chk({tag, "_ack_b"}, {31'd0, ack_b}, 32'd0);
    chk({tag, "_wren"}, {31'd0, ram_wren}, 32'd0);
    chk({tag, "_wraddr"}, {28'd0, ram_wraddr}, 32'd0);
    chk({tag, "_wdata"}, {24'd0, ram_data}, 32'd0);
    chk({tag, "_rdaddr"}, {28'd0, ram_rdaddr}, 32'd0);
    chk({tag, "_disp_addr"}, {28'd0, disp_addr}, 32'd0);
    chk({tag, "_disp_data"}, {24'd0, disp_data}, 32'd0);
    chk({tag, "_disp_valid"}, {31'd0, disp_valid}, 32'd0);
  endtask

  task automatic push_wr(logic b, logic [3:0] a, logic [7:0] d);
    wr_t e;
    e.b = b; e.addr = a; e.data = d;
    wq.push_back(e);
    exp_mem[a] = d;
  endtask

  task automatic push_dp(logic [3:0] a);
    dp_t e;
    e.addr = a; e.data = exp_mem[a];
    dq.push_back(e);
  endtask

  task automatic write_one(logic b, logic [3:0] a, logic [7:0] d);
    bit ok;
    ok = 1'b0;
    push_wr(b, a, d);
    if (b) begin req_b = 1'b1; addr_b = a; data_b = d; end
    else   begin req_a = 1'b1; addr_a = a; data_a = d; end
    for (int i = 0; i < 8; i++) begin
      tick();
      if (b ? ack_b : ack_a) begin ok = 1'b1; break; end
    end
    if (b) req_b = 1'b0; else req_a = 1'b0;
    chk("ack_arrived", {31'd0, ok}, 32'd1);
    tick();
  endtask

  task automatic wait_step(output int n);
    logic [3:0] prev;
    prev = ram_rdaddr;
    n = 99;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (ram_rdaddr != prev) begin n = i; break; end
    end
  endtask

  initial begin
    int n, last;
    logic [3:0] ea;
    for (int i = 0; i < 16; i++) exp_mem[i] = 8'hA0 + 8'(i);

    repeat (3) tick();
    check_all_zero("reset");
    clrn = 1'b1;
    tick();

    // sole requester A
    write_one(1'b0, 4'd3, 8'h02);

    // both requesters held from reset: A, B, A, B every second cycle
    clrn = 1'b0;
    tick(); tick();
    addr_a = 4'd1; data_a = 8'h11; addr_b = 4'd2; data_b = 8'h22;
    push_wr(1'b0, 4'd1, 8'h11); push_wr(1'b1, 4'd2, 8'h22);
    push_wr(1'b0, 4'd1, 8'h11); push_wr(1'b1, 4'd2, 8'h22);
    clrn = 1'b1; req_a = 1'b1; req_b = 1'b1;
    n = 0; last = 0;
    for (int c = 1; c <= 20 && n < 4; c++) begin
      tick();
      if (ack_a || ack_b) begin
        if (n == 0) chk("first_grant_cycle", c, 1);
        else        chk("ack_gap", c - last, 2);
        last = c;
        n++;
        if (n == 4) begin req_a = 1'b0; req_b = 1'b0; end
      end
    end
    chk("pair_write_count", n, 4);
    tick();

    // sole requester B writes 0x01 to address 5
    write_one(1'b1, 4'd5, 8'h01);

    // scan from reset, SCAN_DIV=4: one step every 4 cycles, wraps 15 -> 0
    clrn = 1'b0;
    tick(); tick();
    scan_en = 1'b1;
    clrn = 1'b1;
    for (int k = 1; k <= 18; k++) begin
      ea = 4'(k);
      push_dp(ea);
      wait_step(n);
      chk("step_period", n, 4);
      chk("rdaddr", {28'd0, ram_rdaddr}, {28'd0, ea});
    end

    // pause right after the step to address 2; its capture still lands
    scan_en = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      chk("pause_rdaddr", {28'd0, ram_rdaddr}, 32'd2);
      if (i >= 2) begin
        chk("pause_disp_addr", {28'd0, disp_addr}, 32'd2);
        chk("pause_disp_data", {24'd0, disp_data}, {24'd0, exp_mem[2]});
      end
    end
    scan_en = 1'b1;
    push_dp(4'd3);
    wait_step(n);
    chk("resume_period", n, 4);
    chk("resume_rdaddr", {28'd0, ram_rdaddr}, 32'd3);

    // reset during a write cycle with a capture in flight
    wait_step(n);
    chk("pre_reset_rdaddr", {28'd0, ram_rdaddr}, 32'd4);
    push_wr(1'b0, 4'd9, 8'h99);
    req_a = 1'b1; addr_a = 4'd9; data_a = 8'h99;
    tick();
    chk("write_before_reset", {31'd0, ack_a}, 32'd1);
    clrn = 1'b0; req_a = 1'b0; scan_en = 1'b0;
    req_b = 1'b1; addr_b = 4'd7; data_b = 8'h77;
    tick();
    check_all_zero("midreset");
    tick();
    chk("held_reset_wren", {31'd0, ram_wren}, 32'd0);
    clrn = 1'b1;
    write_one(1'b1, 4'd7, 8'h77);

    repeat (4) tick();
    chk("write_queue_empty", wq.size(), 0);
    chk("disp_queue_empty", dq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
